// File: rtl/vc_sram_ctrl_pkg.sv
// Shared request/response types for the val/rdy SRAM controller.
// VC_SRAM_RESP_ENTRY_T(W) declares the queued response entry for a W-bit data path.
package vc_sram_ctrl_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

endpackage

`define VC_SRAM_RESP_ENTRY_T(W) struct packed { vc_sram_ctrl_pkg::req_type_e typ; logic [(W)-1:0] data; }

// File: rtl/vc_sram_resp_queue.sv
// Circular response queue with count and head peek; registered enq/deq, head is combinational.
// No internal flow control: the owner guarantees no enqueue when full and no dequeue when empty.
module vc_sram_resp_queue #(
  parameter  int p_depth     = 2,
  parameter  int p_nbits     = 33,
  localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1,
  localparam int c_cnt_nbits = $clog2(p_depth + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_nbits-1:0]     enq_data,
  input  logic                   deq_val,
  output logic [p_nbits-1:0]     head_data,
  output logic [c_cnt_nbits-1:0] count
);

  logic [p_nbits-1:0]     entries [p_depth];
  logic [c_ptr_nbits-1:0] head;
  logic [c_ptr_nbits-1:0] tail;

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
    return (p == c_ptr_nbits'(p_depth - 1)) ? '0 : p + c_ptr_nbits'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_val) tail <= ptr_inc(tail);
      if (deq_val) head <= ptr_inc(head);
      if (enq_val && !deq_val)      count <= count + c_cnt_nbits'(1);
      else if (!enq_val && deq_val) count <= count - c_cnt_nbits'(1);
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (enq_val) entries[tail] <= enq_data;
  end

  assign head_data = entries[head];

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (!reset)
    enq_val |-> (count != c_cnt_nbits'(p_depth)));
  a_no_deq_when_empty: assert property (@(posedge clk) disable iff (!reset)
    deq_val |-> (count != '0));

endmodule

// File: rtl/vc_sram_req_resp_ctrl.sv
// Val/rdy front end for a 1rw SRAM (1-cycle read); one in-order response per request, credit-limited queue.
// Define VC_SRAM_CTRL_RESP_BYPASS_EN for 1-cycle responses over a 2-entry queue; default is 2-cycle via 3 entries.
module vc_sram_req_resp_ctrl
  import vc_sram_ctrl_pkg::*;
#(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_type,
  input  logic [c_addr_nbits-1:0]  req_addr,
  input  logic [p_data_nbits-1:0]  req_data,
  input  logic [c_data_nbytes-1:0] req_byte_en,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic                     resp_type,
  output logic [p_data_nbits-1:0]  resp_data,
  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data
);

`ifdef VC_SRAM_CTRL_RESP_BYPASS_EN
  localparam int c_q_depth = 2;
`else
  localparam int c_q_depth = 3;
`endif
  localparam int c_cnt_nbits = $clog2(c_q_depth + 1);

  typedef `VC_SRAM_RESP_ENTRY_T(p_data_nbits) resp_entry_t;
  localparam int c_entry_nbits = $bits(resp_entry_t);

  logic                     req_fire;
  logic                     p1_val;
  req_type_e                p1_type;
  resp_entry_t              p1_entry;
  resp_entry_t              resp_entry;
  logic [c_entry_nbits-1:0] q_head;
  logic [c_cnt_nbits-1:0]   q_count;
  logic                     q_nonempty;
  logic                     q_enq;
  logic                     q_deq;
  logic [c_cnt_nbits:0]     occupancy;

  // Credit counts the in-flight read as well, so SRAM data always has a slot.
  assign occupancy = {1'b0, q_count} + {{c_cnt_nbits{1'b0}}, p1_val};
  assign req_rdy   = occupancy < (c_cnt_nbits + 1)'(c_q_depth);
  assign req_fire  = req_val & req_rdy;

  assign sram_read_en       = req_fire & ~req_type;
  assign sram_write_en      = req_fire & req_type;
  assign sram_read_addr     = req_addr;
  assign sram_write_addr    = req_addr;
  assign sram_write_data    = req_data;
  assign sram_write_byte_en = req_byte_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_val  <= 1'b0;
      p1_type <= REQ_READ;
    end else begin
      p1_val  <= req_fire;
      p1_type <= req_type_e'(req_type);
    end
  end

  always_comb begin
    p1_entry      = '0;
    p1_entry.typ  = p1_type;
    p1_entry.data = (p1_type == REQ_READ) ? sram_read_data : '0;
  end

  assign q_nonempty = (q_count != '0);

`ifdef VC_SRAM_CTRL_RESP_BYPASS_EN
  // Queue head wins; stage 1 answers directly only when nothing older is waiting.
  assign resp_val   = q_nonempty | p1_val;
  assign resp_entry = q_nonempty ? resp_entry_t'(q_head) : p1_entry;
  assign q_enq      = p1_val & ~(~q_nonempty & resp_rdy);
`else
  assign resp_val   = q_nonempty;
  assign resp_entry = resp_entry_t'(q_head);
  assign q_enq      = p1_val;
`endif

  assign q_deq = resp_val & resp_rdy & q_nonempty;

  vc_sram_resp_queue #(
    .p_depth (c_q_depth),
    .p_nbits (c_entry_nbits)
  ) u_resp_queue (
    .clk       (clk),
    .reset     (reset),
    .enq_val   (q_enq),
    .enq_data  (p1_entry),
    .deq_val   (q_deq),
    .head_data (q_head),
    .count     (q_count)
  );

  assign resp_type = resp_val & resp_entry.typ;
  assign resp_data = resp_val ? resp_entry.data : '0;

  a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown(req_val) && !$isunknown(resp_rdy));
  a_type_known: assert property (@(posedge clk) disable iff (!reset)
    req_fire |-> !$isunknown(req_type));
  a_addr_range: assert property (@(posedge clk) disable iff (!reset)
    req_fire |-> (32'(req_addr) < 32'(p_num_entries)));

endmodule
